// File: rtl/pipeline_control_unit_pkg.sv
// Shared pipeline control definitions: FSM state codes and the control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// The control bundle order matches the datapath top, which unpacks it onto the
// PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB enable-gated registers.
package pipeline_control_unit_pkg;

    // Sequencer states. The encoding is binary so the state fits one flop.
    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MDU_WAIT = 1'b1;

    // Enable and flush lines for the PC and pipeline registers.
    // A flush loads a NOP/bubble and wins over the enable at the register.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } pipe_ctrl_t;

    // Every register frozen, nothing flushed (held during reset).
    localparam pipe_ctrl_t CTRL_OFF      = 8'b00000_000;
    // Normal flow: everything advances.
    localparam pipe_ctrl_t CTRL_RUN      = 8'b11111_000;
    // Taken branch: advance, squash the two younger instructions.
    localparam pipe_ctrl_t CTRL_SQUASH   = 8'b11111_110;
    // Load-use: freeze PC and IF/ID, push one bubble into EX.
    localparam pipe_ctrl_t CTRL_BUBBLE   = 8'b00111_010;
    // MDU hold: freeze the front end and EX, drain bubbles into MEM.
    localparam pipe_ctrl_t CTRL_MDU_HOLD = 8'b00011_001;

    // Width of the MDU occupancy counter: it must hold MDU_CYCLES-1.
    function automatic int mdu_cnt_width(input int mdu_cycles);
        return $clog2(mdu_cycles) + 1;
    endfunction

    // A cycle counts as a stall whenever the PC does not advance.
    function automatic logic front_stalled(input pipe_ctrl_t c);
        return !c.pc_en;
    endfunction

endpackage

// File: rtl/pipeline_control_unit_if.sv
// Hazard inputs and pipeline control outputs of the pipeline control unit.
// Latency: n/a (wiring only).
// Backpressure: n/a.
//
// master: the hazard/branch/MDU logic side (drives the hazard inputs).
// slave : the control unit itself (drives enables, flushes, MDU status).
interface pipeline_control_unit_if #(
    parameter int CNT_W = 32
);
    // Hazard and debug inputs.
    logic             branch_taken;
    logic             load_use;
    logic             mdu_start;
    logic             stall_count_clr;

    // Pipeline register controls.
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;

    // MDU status and stall statistics.
    logic             mdu_busy;
    logic             mdu_capture;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output branch_taken, load_use, mdu_start, stall_count_clr,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, exmem_flush,
        input  mdu_busy, mdu_capture, stall_count
    );

    modport slave (
        input  branch_taken, load_use, mdu_start, stall_count_clr,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, exmem_flush,
        output mdu_busy, mdu_capture, stall_count
    );

endinterface

// File: rtl/pipeline_control_unit_stall_counter.sv
// Saturating stall-cycle counter with synchronous clear.
// Latency: count reflects an increment or clear one edge after it is requested.
// Backpressure: none; sticks at all-ones instead of wrapping.
//
// Ports: clk, reset (async, active-low), clr (sync clear, beats inc),
//        inc (count this cycle), count (CNT_W-bit value).
module stall_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_control_unit.sv
// Central sequencer for the pipelined MIPS datapath: enables/flushes, MDU hold.
// Latency: controls decode combinationally, stalls act in the same cycle.
// Backpressure: load-use and MDU occupancy freeze PC and front pipe registers.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-low; all controls read 0 while low
//   bus    - slave modport: hazard inputs in, enables/flushes/MDU status out
//
// Parameters:
//   MDU_CYCLES - cycles an MDU op occupies EX, counting its start cycle (>=1)
//   CNT_W      - width of stall_count
module pipeline_control_unit
    import pipeline_control_unit_pkg::*;
#(
    parameter int MDU_CYCLES = 4,
    parameter int CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_control_unit_if.slave  bus
);

    localparam int MCW = mdu_cnt_width(MDU_CYCLES);

    // With a single-cycle MDU the op never needs to hold EX.
    localparam logic             MDU_STALLS = (MDU_CYCLES >= 2);
    localparam logic [MCW-1:0]   MDU_LOAD   = MCW'(MDU_CYCLES - 1);
    localparam logic [MCW-1:0]   MDU_LAST   = MCW'(1);

    logic [0:0]     state;
    logic [0:0]     state_nxt;
    logic [MCW-1:0] mdu_cnt;
    logic [MCW-1:0] mdu_cnt_nxt;

    pipe_ctrl_t     ctrl;
    logic           mdu_busy;
    logic           mdu_capture;
    logic           stall_inc;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_RUN;
            mdu_cnt <= '0;
        end else begin
            state   <= state_nxt;
            mdu_cnt <= mdu_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and output decode
    //
    // mdu_cnt holds the number of EX cycles the MDU op still needs after
    // the current one; the start cycle loads MDU_CYCLES-1 so the op sits
    // in EX for exactly MDU_CYCLES cycles, the last one being the release.
    // Reset gates every output so an aborted MDU op never pulses capture.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        mdu_cnt_nxt = mdu_cnt;
        ctrl        = CTRL_OFF;
        mdu_busy    = 1'b0;
        mdu_capture = 1'b0;

        if (reset) begin
            case (state)
                ST_RUN: begin
                    if (bus.mdu_start && MDU_STALLS) begin
                        // Hazard inputs are irrelevant: EX is about to be held.
                        ctrl        = CTRL_MDU_HOLD;
                        mdu_busy    = 1'b1;
                        state_nxt   = ST_MDU_WAIT;
                        mdu_cnt_nxt = MDU_LOAD;
                    end else if (bus.branch_taken) begin
                        // The load_use consumer is among the squashed.
                        ctrl = CTRL_SQUASH;
                    end else if (bus.load_use) begin
                        ctrl = CTRL_BUBBLE;
                    end else begin
                        ctrl = CTRL_RUN;
                    end
                end

                ST_MDU_WAIT: begin
                    // All hazard inputs are ignored while the MDU owns EX.
                    if (mdu_cnt > MDU_LAST) begin
                        ctrl        = CTRL_MDU_HOLD;
                        mdu_busy    = 1'b1;
                        mdu_cnt_nxt = mdu_cnt - MCW'(1);
                    end else begin
                        ctrl        = CTRL_RUN;
                        mdu_capture = 1'b1;
                        mdu_cnt_nxt = '0;
                        state_nxt   = ST_RUN;
                    end
                end

                default: begin
                    state_nxt   = ST_RUN;
                    mdu_cnt_nxt = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stall statistics
    // ------------------------------------------------------------------
    assign stall_inc = front_stalled(ctrl) && reset;

    stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.stall_count_clr),
        .inc   (stall_inc),
        .count (bus.stall_count)
    );

    // ------------------------------------------------------------------
    // Output unpacking
    // ------------------------------------------------------------------
    assign bus.pc_en       = ctrl.pc_en;
    assign bus.ifid_en     = ctrl.ifid_en;
    assign bus.idex_en     = ctrl.idex_en;
    assign bus.exmem_en    = ctrl.exmem_en;
    assign bus.memwb_en    = ctrl.memwb_en;
    assign bus.ifid_flush  = ctrl.ifid_flush;
    assign bus.idex_flush  = ctrl.idex_flush;
    assign bus.exmem_flush = ctrl.exmem_flush;
    assign bus.mdu_busy    = mdu_busy;
    assign bus.mdu_capture = mdu_capture;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: three builds (MDU_CYCLES=4/CNT_W=32,
// MDU_CYCLES=1, MDU_CYCLES=4/CNT_W=4) share one stimulus stream and are each
// compared every cycle against a cycle-level reference model.
module tb_pipeline_control_unit;

    // Output vector order:
    // {pc,ifid,idex,exmem,memwb, ifid_fl,idex_fl,exmem_fl, busy, capture}
    localparam logic [9:0] P_ZERO = 10'b00000_000_00;
    localparam logic [9:0] P_IDLE = 10'b11111_000_00;
    localparam logic [9:0] P_LU   = 10'b00111_010_00;
    localparam logic [9:0] P_BR   = 10'b11111_110_00;
    localparam logic [9:0] P_HOLD = 10'b00011_001_10;
    localparam logic [9:0] P_REL  = 10'b11111_000_01;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic br = 1'b0, lu = 1'b0, ms = 1'b0, clr = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipeline_control_unit_if #(.CNT_W(32)) bus0 ();
    pipeline_control_unit_if #(.CNT_W(32)) bus1 ();
    pipeline_control_unit_if #(.CNT_W(4))  bus2 ();

    pipeline_control_unit #(.MDU_CYCLES(4), .CNT_W(32)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    pipeline_control_unit #(.MDU_CYCLES(1), .CNT_W(32)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    pipeline_control_unit #(.MDU_CYCLES(4), .CNT_W(4))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

    assign bus0.branch_taken = br;  assign bus0.load_use = lu;
    assign bus0.mdu_start    = ms;  assign bus0.stall_count_clr = clr;
    assign bus1.branch_taken = br;  assign bus1.load_use = lu;
    assign bus1.mdu_start    = ms;  assign bus1.stall_count_clr = clr;
    assign bus2.branch_taken = br;  assign bus2.load_use = lu;
    assign bus2.mdu_start    = ms;  assign bus2.stall_count_clr = clr;

    logic [9:0]  act  [3];
    logic [31:0] actc [3];

    assign act[0] = {bus0.pc_en, bus0.ifid_en, bus0.idex_en, bus0.exmem_en, bus0.memwb_en,
                     bus0.ifid_flush, bus0.idex_flush, bus0.exmem_flush, bus0.mdu_busy, bus0.mdu_capture};
    assign act[1] = {bus1.pc_en, bus1.ifid_en, bus1.idex_en, bus1.exmem_en, bus1.memwb_en,
                     bus1.ifid_flush, bus1.idex_flush, bus1.exmem_flush, bus1.mdu_busy, bus1.mdu_capture};
    assign act[2] = {bus2.pc_en, bus2.ifid_en, bus2.idex_en, bus2.exmem_en, bus2.memwb_en,
                     bus2.ifid_flush, bus2.idex_flush, bus2.exmem_flush, bus2.mdu_busy, bus2.mdu_capture};
    assign actc[0] = bus0.stall_count;
    assign actc[1] = bus1.stall_count;
    assign actc[2] = {28'b0, bus2.stall_count};

    // ------------------------------------------------------------------
    // Reference model: an MDU op is tracked by how many EX cycles it has
    // already used (age, 0 = no op in EX); stalls counted as plain integers.
    // ------------------------------------------------------------------
    int         age  [3];
    longint     sc   [3];
    logic [9:0] pred [3];

    function automatic int mdu_cycles_of(input int k);
        return (k == 1) ? 1 : 4;
    endfunction

    function automatic longint cnt_max_of(input int k);
        return (k == 2) ? 64'd15 : 64'hFFFF_FFFF;
    endfunction

    function automatic logic [9:0] predict(input int k, input logic b, input logic l, input logic m);
        if (!reset) return P_ZERO;
        if (age[k] > 0) return (age[k] + 1 == mdu_cycles_of(k)) ? P_REL : P_HOLD;
        if (m && mdu_cycles_of(k) > 1) return P_HOLD;
        if (b) return P_BR;
        if (l) return P_LU;
        return P_IDLE;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            age[k] = 0;
            sc[k]  = 0;
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Drive inputs on the falling edge, then compare all builds to the model.
    task automatic drive_and_check(input logic b, input logic l, input logic m, input logic c);
        @(negedge clk);
        br = b; lu = l; ms = m; clr = c;
        #1;
        for (int k = 0; k < 3; k++) begin
            pred[k] = predict(k, b, l, m);
            check($sformatf("dut%0d ctrl", k), 64'(act[k]), 64'(pred[k]));
            check($sformatf("dut%0d count", k), 64'(actc[k]), sc[k]);
        end
    endtask

    // Let the rising edge happen and move the model forward with it.
    task automatic advance();
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                if (age[k] > 0)
                    age[k] = (age[k] + 1 == mdu_cycles_of(k)) ? 0 : age[k] + 1;
                else if (ms && mdu_cycles_of(k) > 1)
                    age[k] = 1;
                if (clr)
                    sc[k] = 0;
                else if (!pred[k][9])
                    sc[k] = (sc[k] + 1 > cnt_max_of(k)) ? cnt_max_of(k) : sc[k] + 1;
            end
        end
    endtask

    task automatic cycle(input logic b, input logic l, input logic m, input logic c);
        drive_and_check(b, l, m, c);
        advance();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic rst_pulse();
        #2;
        br = 1'b0; lu = 1'b0; ms = 1'b0; clr = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("dut%0d reset ctrl", k), 64'(act[k]), 64'(P_ZERO));
            check($sformatf("dut%0d reset count", k), 64'(actc[k]), 64'd0);
        end
        #1;
        reset = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Directed table for the MDU_CYCLES=4 / CNT_W=32 build, from reset.
    // ------------------------------------------------------------------
    typedef struct {
        logic        b, l, m, c;
        logic [9:0]  exp;
        logic [31:0] cnt;
    } vec_t;

    vec_t tab [17];

    function automatic vec_t mk(input logic b, input logic l, input logic m, input logic c,
                                input logic [9:0] e, input logic [31:0] n);
        vec_t v;
        v.b = b; v.l = l; v.m = m; v.c = c; v.exp = e; v.cnt = n;
        return v;
    endfunction

    initial begin
        tab[0]  = mk(0, 0, 0, 0, P_IDLE, 0);
        tab[1]  = mk(0, 1, 0, 0, P_LU,   0);   // single load-use bubble
        tab[2]  = mk(0, 0, 0, 0, P_IDLE, 1);
        tab[3]  = mk(1, 1, 0, 0, P_BR,   1);   // branch beats load-use
        tab[4]  = mk(0, 0, 0, 0, P_IDLE, 1);   // branch did not stall
        tab[5]  = mk(0, 0, 1, 0, P_HOLD, 1);   // MDU start, cycle 0
        tab[6]  = mk(1, 0, 0, 0, P_HOLD, 2);   // branch ignored, cycle 1
        tab[7]  = mk(0, 0, 0, 0, P_HOLD, 3);   // cycle 2
        tab[8]  = mk(0, 0, 0, 0, P_REL,  4);   // cycle 3: capture
        tab[9]  = mk(0, 0, 0, 0, P_IDLE, 4);
        tab[10] = mk(0, 0, 0, 1, P_IDLE, 4);   // clear request
        tab[11] = mk(0, 0, 0, 0, P_IDLE, 0);
        tab[12] = mk(1, 1, 1, 0, P_HOLD, 0);   // MDU beats branch and load-use
        tab[13] = mk(0, 1, 0, 0, P_HOLD, 1);
        tab[14] = mk(0, 0, 1, 0, P_HOLD, 2);
        tab[15] = mk(0, 0, 0, 0, P_REL,  3);
        tab[16] = mk(0, 0, 0, 0, P_IDLE, 3);

        model_reset();

        // Reset held across edges.
        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("dut%0d por ctrl", k), 64'(act[k]), 64'(P_ZERO));
            check($sformatf("dut%0d por count", k), 64'(actc[k]), 64'd0);
        end
        #2;
        reset = 1'b1;

        // Directed table.
        for (int i = 0; i < 17; i++) begin
            drive_and_check(tab[i].b, tab[i].l, tab[i].m, tab[i].c);
            check($sformatf("tab%0d ctrl", i), 64'(act[0]), 64'(tab[i].exp));
            check($sformatf("tab%0d count", i), 64'(actc[0]), 64'(tab[i].cnt));
            advance();
        end

        // MDU_CYCLES=1 build never stalls on mdu_start.
        drive_and_check(0, 0, 1, 0);
        check("mdu1 start idle", 64'(act[1]), 64'(P_IDLE));
        advance();

        // Reset in the middle of an MDU op: no capture, clean restart.
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        check("pre-reset busy", 64'(bus0.mdu_busy), 64'd1);
        rst_pulse();
        drive_and_check(0, 0, 0, 0);
        check("post-reset idle", 64'(act[0]), 64'(P_IDLE));
        advance();
        cycle(0, 0, 0, 0);

        // Saturation on the 4-bit build, then clear wins over increment.
        repeat (20) cycle(0, 1, 0, 0);
        drive_and_check(0, 1, 0, 1);
        check("sat count", 64'(actc[2]), 64'd15);
        advance();
        drive_and_check(0, 0, 0, 0);
        check("sat cleared", 64'(actc[2]), 64'd0);
        advance();

        // Randomised traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 60) == 0) rst_pulse();
            cycle(logic'($urandom_range(0, 3) == 0),
                  logic'($urandom_range(0, 3) == 0),
                  logic'($urandom_range(0, 5) == 0),
                  logic'($urandom_range(0, 24) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
